pipelined_barrel_shifter: RTL

- Parametrised, pipelined successor to the 8-bit combinational rotator. Generalises width and adds five shift modes, carry-out and zero flags, and a valid/ready handshake on both sides.
- One log-stage per pipeline register, so timing holds at WIDTH=32/64.
- Sits between the ALU operand mux and the writeback register. Also usable standalone for shift/rotate instructions.

---
 rtl/pipelined_barrel_shifter_if.sv | 36 +++
 rtl/pipelined_barrel_shifter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for pipelined_barrel_shifter.
//   slave  : the shifter (consumes in_*, produces out_*, drives in_ready)
//   master : the producer/consumer pair talking to the shifter
// Signals:
//   in_valid/in_ready   input-side handshake
//   in_data/in_shamt    operand and shift amount (0..WIDTH-1)
//   in_mode             000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others pass
//   out_valid/out_ready output-side handshake
//   out_data/out_carry/out_zero  result, last bit shifted out, result==0
interface pipelined_barrel_shifter_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_shamt;
   logic [2:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic             out_zero;

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_carry, out_zero
   );

   modport master (
      output in_valid, in_data, in_shamt, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_carry, out_zero
   );

endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logarithmic shifter/rotator with valid/ready on both sides.
// Stage k conditionally shifts by 2^k (when shamt bit k is set) and registers
// the beat, so latency is SHW cycles and throughput is one beat per cycle.
// WIDTH must be a power of two and at least 4; SHW is derived.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears every stage and the outputs
//   bus    slave side of pipelined_barrel_shifter_if (see interface header)
module pipelined_barrel_shifter #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic rst_n,
   pipelined_barrel_shifter_if.slave bus
);

   localparam logic [2:0] MODE_SLL = 3'b000;
   localparam logic [2:0] MODE_SRL = 3'b001;
   localparam logic [2:0] MODE_SRA = 3'b010;
   localparam logic [2:0] MODE_ROL = 3'b011;
   localparam logic [2:0] MODE_ROR = 3'b100;

   // pipe_*[k] is the input of stage k; pipe_*[SHW] is the output register.
   logic [WIDTH-1:0] pipe_data  [SHW+1];
   logic [2:0]       pipe_mode  [SHW];
   logic [SHW-1:0]   pipe_shamt [SHW];
   logic [SHW:0]     pipe_valid;
   logic [SHW:0]     pipe_carry;
   logic [WIDTH-1:0] last_d;
   logic             zero_q;
   logic             stall;
   logic             adv;

   // The whole pipeline moves as one; a held output freezes every stage.
   assign stall        = pipe_valid[SHW] & ~bus.out_ready;
   assign adv          = ~stall;
   assign bus.in_ready = adv;

   assign pipe_data[0]  = bus.in_data;
   assign pipe_mode[0]  = bus.in_mode;
   assign pipe_shamt[0] = bus.in_shamt;
   assign pipe_valid[0] = bus.in_valid;
   assign pipe_carry[0] = 1'b0;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int S = 1 << k;

      logic [WIDTH-1:0] data_d;
      logic [WIDTH-1:0] data_q;
      logic             carry_d;
      logic             carry_q;
      logic             valid_q;

      // Carry is the last bit leaving in this stage; a later stage that also
      // shifts overwrites it, so the final value is the overall last-out bit.
      always_comb begin
         data_d  = pipe_data[k];
         carry_d = pipe_carry[k];
         if (pipe_shamt[k][k]) begin
            case (pipe_mode[k])
               MODE_SLL: begin
                  data_d  = pipe_data[k] << S;
                  carry_d = pipe_data[k][WIDTH-S];
               end
               MODE_SRL: begin
                  data_d  = pipe_data[k] >> S;
                  carry_d = pipe_data[k][S-1];
               end
               MODE_SRA: begin
                  data_d  = $signed(pipe_data[k]) >>> S;
                  carry_d = pipe_data[k][S-1];
               end
               MODE_ROL: begin
                  data_d  = (pipe_data[k] << S) | (pipe_data[k] >> (WIDTH - S));
                  carry_d = pipe_data[k][WIDTH-S];
               end
               MODE_ROR: begin
                  data_d  = (pipe_data[k] >> S) | (pipe_data[k] << (WIDTH - S));
                  carry_d = pipe_data[k][S-1];
               end
               default: begin
                  data_d  = pipe_data[k];
                  carry_d = pipe_carry[k];
               end
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            data_q  <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
         end else if (adv) begin
            data_q  <= data_d;
            carry_q <= carry_d;
            valid_q <= pipe_valid[k];
         end
      end

      assign pipe_data[k+1]  = data_q;
      assign pipe_carry[k+1] = carry_q;
      assign pipe_valid[k+1] = valid_q;

      // Mode and shamt ride with the beat; the last stage has no consumer.
      if (k < SHW - 1) begin : g_ctl
         logic [2:0]     mode_q;
         logic [SHW-1:0] shamt_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               mode_q  <= '0;
               shamt_q <= '0;
            end else if (adv) begin
               mode_q  <= pipe_mode[k];
               shamt_q <= pipe_shamt[k];
            end
         end

         assign pipe_mode[k+1]  = mode_q;
         assign pipe_shamt[k+1] = shamt_q;
      end

      if (k == SHW - 1) begin : g_last
         assign last_d = data_d;
      end
   end

   // Zero flag is evaluated on the final-stage next data so it lands together
   // with out_data instead of adding a cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
      end else if (adv) begin
         zero_q <= (last_d == '0);
      end
   end

   assign bus.out_valid = pipe_valid[SHW];
   assign bus.out_data  = pipe_data[SHW];
   assign bus.out_carry = pipe_carry[SHW];
   assign bus.out_zero  = zero_q;

endmodule
